// File: rtl/lpc_post_code_fifo.sv
// rtl/lpc_post_code_fifo.sv - LPC POST-code port capture FIFO with read-back of last code
//
// Purpose:
//   Sits behind lpc_periph. I/O writes to PORT_ADDR are acknowledged and pushed
//   into a FIFO; I/O reads of PORT_ADDR return the most recent code written.
//   The FIFO drains to a local consumer over a valid/ready pair.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   lpc_addr_i, lpc_wdata_i           address / write data from lpc_periph
//   lpc_data_wr_i, lpc_wr_done_o      write request (held) / write acknowledge
//   lpc_rd_req_i, lpc_rd_done_i       read request (held) / read data taken
//   lpc_rdata_o, lpc_data_rd_o        read data / read data valid
//   code_valid_o, code_data_o         FIFO head toward the consumer
//   code_ready_i                      consumer pop strobe (with code_valid_o)
//   level_o                           FIFO occupancy, 0..DEPTH
//   overflow_cnt_o                    dropped writes, saturating
//   clear_i                           flush FIFO and zero overflow counter

module lpc_post_code_fifo #(
    parameter logic [15:0] PORT_ADDR = 16'h0080,
    parameter int          DEPTH     = 16,
    parameter int          PTR_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [15:0]      lpc_addr_i,
    input  logic [7:0]       lpc_wdata_i,
    input  logic             lpc_data_wr_i,
    output logic             lpc_wr_done_o,
    input  logic             lpc_rd_req_i,
    output logic [7:0]       lpc_rdata_o,
    output logic             lpc_data_rd_o,
    input  logic             lpc_rd_done_i,
    output logic             code_valid_o,
    output logic [7:0]       code_data_o,
    input  logic             code_ready_i,
    output logic [PTR_W:0]   level_o,
    output logic [7:0]       overflow_cnt_o,
    input  logic             clear_i
);

    typedef enum logic {
        W_IDLE,
        W_ACK
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DRV,
        R_REL
    } rd_state_t;

    wr_state_t      wr_state_q, wr_state_d;
    rd_state_t      rd_state_q, rd_state_d;
    logic [7:0]     last_code_q, last_code_d;
    logic [7:0]     rdata_q, rdata_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]     overflow_cnt_q, overflow_cnt_d;
    logic [7:0]     mem_q [DEPTH];

    logic           addr_hit;
    logic           wr_req;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic [PTR_W:0] level;

    assign addr_hit = (lpc_addr_i == PORT_ADDR);

    // Pointers carry one extra wrap bit, so the plain difference is the occupancy.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == (PTR_W+1)'(DEPTH));
    assign empty = (level == '0);

    // Write FSM: wr_req pulses exactly once per request, on the W_IDLE edge.
    always_comb begin
        wr_state_d  = wr_state_q;
        last_code_d = last_code_q;
        wr_req      = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (lpc_data_wr_i && addr_hit) begin
                    wr_req      = 1'b1;
                    last_code_d = lpc_wdata_i;
                    wr_state_d  = W_ACK;
                end
            end
            W_ACK: begin
                if (!lpc_data_wr_i) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read FSM: data is captured on entry to R_DRV so it stays stable while driven.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (lpc_rd_req_i && addr_hit) begin
                    rd_state_d = R_DRV;
                    rdata_d    = last_code_q;
                end
            end
            R_DRV: begin
                if (lpc_rd_done_i) begin
                    rd_state_d = R_REL;
                end
            end
            R_REL: begin
                if (!lpc_rd_req_i) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // FIFO control. A pop frees the slot a same-cycle push needs, so a full FIFO
    // with a concurrent pop still accepts the write. clear_i overrides both.
    always_comb begin
        pop            = !empty && code_ready_i && !clear_i;
        push           = wr_req && (!full || pop) && !clear_i;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        overflow_cnt_d = overflow_cnt_q;
        if (clear_i) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            overflow_cnt_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_req && !push && (overflow_cnt_q != 8'hFF)) begin
                overflow_cnt_d = overflow_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q     <= W_IDLE;
            rd_state_q     <= R_IDLE;
            last_code_q    <= 8'h00;
            rdata_q        <= 8'h00;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            overflow_cnt_q <= 8'h00;
        end else begin
            wr_state_q     <= wr_state_d;
            rd_state_q     <= rd_state_d;
            last_code_q    <= last_code_d;
            rdata_q        <= rdata_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            overflow_cnt_q <= overflow_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= lpc_wdata_i;
        end
    end

    assign lpc_wr_done_o  = (wr_state_q == W_ACK);
    assign lpc_data_rd_o  = (rd_state_q == R_DRV);
    assign lpc_rdata_o    = rdata_q;
    assign code_valid_o   = !empty;
    // Gated so an empty FIFO (including after reset) presents zero rather than stale data.
    assign code_data_o    = empty ? 8'h00 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign level_o        = level;
    assign overflow_cnt_o = overflow_cnt_q;

endmodule

// File: tb/tb_lpc_post_code_fifo.sv
// tb/tb_lpc_post_code_fifo.sv - self-checking bench for lpc_post_code_fifo
module tb_lpc_post_code_fifo;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam logic [15:0] PORT = 16'h0080;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      lpc_addr;
    logic [7:0]       lpc_wdata;
    logic             data_wr;
    logic             wr_done;
    logic             rd_req;
    logic [7:0]       rdata;
    logic             data_rd;
    logic             rd_done;
    logic             code_valid;
    logic [7:0]       code_data;
    logic             code_ready;
    logic [PTR_W:0]   level;
    logic [7:0]       ovf;
    logic             clear;

    int vectors = 0;
    int miscompares = 0;

    byte unsigned mq[$];
    logic [7:0]   m_last;
    int           m_ovf;

    always #5 clk = ~clk;

    lpc_post_code_fifo #(.PORT_ADDR(PORT), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .lpc_addr_i(lpc_addr),
        .lpc_wdata_i(lpc_wdata),
        .lpc_data_wr_i(data_wr),
        .lpc_wr_done_o(wr_done),
        .lpc_rd_req_i(rd_req),
        .lpc_rdata_o(rdata),
        .lpc_data_rd_o(data_rd),
        .lpc_rd_done_i(rd_done),
        .code_valid_o(code_valid),
        .code_data_o(code_data),
        .code_ready_i(code_ready),
        .level_o(level),
        .overflow_cnt_o(ovf),
        .clear_i(clear)
    );

    // One clock: inputs were set at the preceding negedge; model follows the
    // rules for that edge; returns at the next negedge.
    task automatic tick(input bit new_wr);
        bit pop_m;
        pop_m = (mq.size() != 0) && code_ready;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_last = 8'h00;
            m_ovf  = 0;
        end else begin
            if (new_wr) m_last = lpc_wdata;
            if (clear) begin
                mq.delete();
                m_ovf = 0;
            end else begin
                if (pop_m) void'(mq.pop_front());
                if (new_wr) begin
                    if (mq.size() < DEPTH) mq.push_back(lpc_wdata);
                    else if (m_ovf < 255) m_ovf++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        bit hit;
        hit = (addr == PORT);
        lpc_addr = addr; lpc_wdata = data; data_wr = 1'b1;
        tick(hit);
        vectors++; if (wr_done !== hit) begin miscompares++; $display("FAIL wr_done_ack: got %0b want %0b addr %h", wr_done, hit, addr); end
        data_wr = 1'b0;
        tick(1'b0);
        vectors++; if (wr_done !== 1'b0) begin miscompares++; $display("FAIL wr_done_release: got %0b want 0", wr_done); end
    endtask

    task automatic do_read(input logic [15:0] addr);
        bit hit;
        logic [7:0] exp;
        hit = (addr == PORT);
        exp = m_last;
        lpc_addr = addr; rd_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick(1'b0);
            vectors++; if (data_rd !== hit) begin miscompares++; $display("FAIL data_rd: got %0b want %0b", data_rd, hit); end
            if (hit) begin
                vectors++; if (rdata !== exp) begin miscompares++; $display("FAIL rdata: got %h want %h", rdata, exp); end
            end
        end
        if (hit) begin
            rd_done = 1'b1;
            tick(1'b0);
            vectors++; if (data_rd !== 1'b0) begin miscompares++; $display("FAIL data_rd_drop: got %0b want 0", data_rd); end
            rd_done = 1'b0;
        end
        rd_req = 1'b0;
        tick(1'b0);
        vectors++; if (data_rd !== 1'b0) begin miscompares++; $display("FAIL data_rd_idle: got %0b want 0", data_rd); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        vectors++; if (wr_done !== 1'b0)  begin miscompares++; $display("FAIL rst_wr_done: got %0b want 0", wr_done); end
        vectors++; if (data_rd !== 1'b0)  begin miscompares++; $display("FAIL rst_data_rd: got %0b want 0", data_rd); end
        vectors++; if (rdata !== 8'h00)   begin miscompares++; $display("FAIL rst_rdata: got %h want 00", rdata); end
        vectors++; if (code_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b want 0", code_valid); end
        vectors++; if (code_data !== 8'h00) begin miscompares++; $display("FAIL rst_code_data: got %h want 00", code_data); end
        vectors++; if (level !== 5'd0)    begin miscompares++; $display("FAIL rst_level: got %0d want 0", level); end
        vectors++; if (ovf !== 8'h00)     begin miscompares++; $display("FAIL rst_ovf: got %h want 00", ovf); end
        rst = 1'b0;
        tick(1'b0);
    endtask

    task automatic test_write_basic;
        lpc_addr = PORT; lpc_wdata = 8'h5A; data_wr = 1'b1;
        tick(1'b1);
        for (int k = 0; k < 3; k++) begin
            vectors++; if (wr_done !== 1'b1) begin miscompares++; $display("FAIL wb_wr_done_held: got %0b want 1 cycle %0d", wr_done, k); end
            tick(1'b0);
        end
        vectors++; if (level !== 5'd1)      begin miscompares++; $display("FAIL wb_level: got %0d want 1", level); end
        vectors++; if (code_valid !== 1'b1) begin miscompares++; $display("FAIL wb_valid: got %0b want 1", code_valid); end
        vectors++; if (code_data !== 8'h5A) begin miscompares++; $display("FAIL wb_data: got %h want 5a", code_data); end
        data_wr = 1'b0;
        tick(1'b0);
        vectors++; if (wr_done !== 1'b0)    begin miscompares++; $display("FAIL wb_wr_done_drop: got %0b want 0", wr_done); end
    endtask

    task automatic test_nonmatch;
        logic [PTR_W:0] lvl0;
        lvl0 = (PTR_W+1)'(mq.size());
        lpc_addr = 16'hF0F0; lpc_wdata = 8'h11; data_wr = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0);
            vectors++; if (wr_done !== 1'b0) begin miscompares++; $display("FAIL nm_wr_done: got %0b want 0 cycle %0d", wr_done, k); end
        end
        vectors++; if (level !== lvl0) begin miscompares++; $display("FAIL nm_level: got %0d want %0d", level, lvl0); end
        data_wr = 1'b0;
        tick(1'b0);
    endtask

    task automatic test_overflow;
        clear = 1'b1; tick(1'b0); clear = 1'b0;
        code_ready = 1'b0;
        for (int i = 0; i <= 16; i++) do_write(PORT, 8'(i));
        vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL of_level: got %0d want 16", level); end
        vectors++; if (ovf !== 8'd1)    begin miscompares++; $display("FAIL of_ovf: got %0d want 1", ovf); end
        code_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vectors++; if (code_valid !== 1'b1 || code_data !== 8'(i)) begin miscompares++; $display("FAIL of_drain: got valid %0b data %h want 1 %h", code_valid, code_data, 8'(i)); end
            tick(1'b0);
        end
        code_ready = 1'b0;
        vectors++; if (code_valid !== 1'b0) begin miscompares++; $display("FAIL of_empty: got %0b want 0", code_valid); end
    endtask

    task automatic test_read;
        logic [PTR_W:0] lvl0;
        do_write(PORT, 8'hA5);
        lvl0 = (PTR_W+1)'(mq.size());
        do_read(PORT);
        vectors++; if (rdata !== 8'hA5) begin miscompares++; $display("FAIL rd_value: got %h want a5", rdata); end
        vectors++; if (level !== lvl0)  begin miscompares++; $display("FAIL rd_level: got %0d want %0d", level, lvl0); end
    endtask

    task automatic test_full_push_pop;
        clear = 1'b1; tick(1'b0); clear = 1'b0;
        code_ready = 1'b0;
        for (int i = 0; i < 16; i++) do_write(PORT, 8'(8'h20 + i));
        lpc_addr = PORT; lpc_wdata = 8'hEE; data_wr = 1'b1; code_ready = 1'b1;
        tick(1'b1);
        code_ready = 1'b0;
        vectors++; if (level !== 5'd16)     begin miscompares++; $display("FAIL fp_level: got %0d want 16", level); end
        vectors++; if (ovf !== 8'h00)       begin miscompares++; $display("FAIL fp_ovf: got %0d want 0", ovf); end
        vectors++; if (code_data !== 8'h21) begin miscompares++; $display("FAIL fp_head: got %h want 21", code_data); end
        data_wr = 1'b0;
        tick(1'b0);
    endtask

    task automatic test_reset_mid;
        lpc_addr = PORT; lpc_wdata = 8'hC3; data_wr = 1'b1;
        tick(1'b1);
        vectors++; if (wr_done !== 1'b1) begin miscompares++; $display("FAIL rm_pre_done: got %0b want 1", wr_done); end
        rst = 1'b1; data_wr = 1'b0;
        tick(1'b0);
        vectors++; if (wr_done !== 1'b0)    begin miscompares++; $display("FAIL rm_wr_done: got %0b want 0", wr_done); end
        vectors++; if (rdata !== 8'h00)     begin miscompares++; $display("FAIL rm_rdata: got %h want 00", rdata); end
        vectors++; if (code_valid !== 1'b0) begin miscompares++; $display("FAIL rm_valid: got %0b want 0", code_valid); end
        vectors++; if (level !== 5'd0)      begin miscompares++; $display("FAIL rm_level: got %0d want 0", level); end
        vectors++; if (ovf !== 8'h00)       begin miscompares++; $display("FAIL rm_ovf: got %h want 00", ovf); end
        rst = 1'b0;
        tick(1'b0);
        do_read(PORT);
    endtask

    task automatic test_saturate_clear;
        code_ready = 1'b0;
        for (int i = 0; i < 300; i++) do_write(PORT, 8'(i));
        vectors++; if (ovf !== 8'hFF)   begin miscompares++; $display("FAIL sat_ovf: got %h want ff", ovf); end
        vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL sat_level: got %0d want 16", level); end
        clear = 1'b1; tick(1'b0); clear = 1'b0;
        vectors++; if (ovf !== 8'h00)       begin miscompares++; $display("FAIL clr_ovf: got %h want 00", ovf); end
        vectors++; if (level !== 5'd0)      begin miscompares++; $display("FAIL clr_level: got %0d want 0", level); end
        vectors++; if (code_valid !== 1'b0) begin miscompares++; $display("FAIL clr_valid: got %0b want 0", code_valid); end
    endtask

    task automatic test_clear_with_write;
        for (int i = 0; i < 3; i++) do_write(PORT, 8'(8'h40 + i));
        lpc_addr = PORT; lpc_wdata = 8'h7E; data_wr = 1'b1; clear = 1'b1;
        tick(1'b1);
        clear = 1'b0;
        vectors++; if (wr_done !== 1'b1) begin miscompares++; $display("FAIL cw_wr_done: got %0b want 1", wr_done); end
        vectors++; if (level !== 5'd0)   begin miscompares++; $display("FAIL cw_level: got %0d want 0", level); end
        data_wr = 1'b0;
        tick(1'b0);
        do_read(PORT);
        vectors++; if (rdata !== 8'h7E)  begin miscompares++; $display("FAIL cw_last_code: got %h want 7e", rdata); end
    endtask

    task automatic test_random;
        int op;
        logic [15:0] a;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            code_ready = ($urandom_range(0, 2) == 0);
            if (op <= 4) begin
                do_write(PORT, 8'($urandom));
            end else if (op == 5) begin
                a = 16'($urandom);
                if (a == PORT) a = 16'h0081;
                do_write(a, 8'($urandom));
            end else if (op == 6) begin
                do_read(PORT);
            end else if (op == 7) begin
                tick(1'b0);
            end else if (op == 8) begin
                clear = 1'b1; tick(1'b0); clear = 1'b0;
            end else begin
                code_ready = 1'b1; tick(1'b0);
            end
            vectors++; if (level !== (PTR_W+1)'(mq.size())) begin miscompares++; $display("FAIL rnd_level: got %0d want %0d op %0d", level, mq.size(), n); end
            vectors++; if (code_valid !== (mq.size() != 0)) begin miscompares++; $display("FAIL rnd_valid: got %0b want %0b op %0d", code_valid, mq.size() != 0, n); end
            vectors++; if (ovf !== 8'(m_ovf)) begin miscompares++; $display("FAIL rnd_ovf: got %0d want %0d op %0d", ovf, m_ovf, n); end
            if (mq.size() != 0) begin
                vectors++; if (code_data !== mq[0]) begin miscompares++; $display("FAIL rnd_head: got %h want %h op %0d", code_data, mq[0], n); end
            end
        end
        code_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lpc_addr = 16'h0; lpc_wdata = 8'h0; data_wr = 1'b0;
        rd_req = 1'b0; rd_done = 1'b0; code_ready = 1'b0; clear = 1'b0;
        m_last = 8'h00; m_ovf = 0;
        @(negedge clk);
        test_reset;
        test_write_basic;
        test_nonmatch;
        test_overflow;
        test_read;
        test_full_push_pop;
        test_reset_mid;
        test_saturate_clear;
        test_clear_with_write;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
